// File: rtl/aurora_pkt_pkg.sv
// ============================================================================
// Module      : aurora_pkt_pkg
// Description : Shared constants for the Aurora DFX packetisation, used by
//               the transmit arbiter and the receive-side decapsulator. It
//               defines the beat header field positions, the fragment
//               geometry and the state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aurora_pkt_pkg;

  // Fragment geometry: 18 full 55-bit fragments plus one 44-bit tail.
  localparam int         NUMBER_PACKET  = 19;
  localparam int         FRAG_WIDTH     = 55;
  localparam logic [4:0] LAST_FRAG      = 5'd18;
  localparam int         LAST_FRAG_BITS = 44;

  // Beat header layout.
  localparam int SRC_LSB     = 0;
  localparam int SRC_MSB     = 1;
  localparam int PKT_LSB     = 2;
  localparam int PKT_MSB     = 6;
  localparam int PAYLOAD_LSB = 9;

  // Transmit scheduler state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/aurora_tx_arbiter_if.sv
// ============================================================================
// Module      : aurora_tx_arbiter_if
// Description : AXI-stream style beat channel toward the Aurora link.
// Ports       : m_axis_tdata/tvalid/tlast (master -> slave),
//               m_axis_tready (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aurora_tx_arbiter_if #(
  parameter int AURORA_DATA_WIDTH = 64
);
  logic [AURORA_DATA_WIDTH-1:0] m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  logic                         m_axis_tlast;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module      : rr_arbiter_4
// Description : Combinational 4-way round-robin pick. The search starts at
//               i_ptr and wraps, and the first set request wins.
// Ports       : i_req[3:0] requests, i_ptr[1:0] search start,
//               o_onehot[3:0] winner, o_idx[1:0] winner index,
//               o_valid any request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_onehot,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [1:0] w_cand;

  always_comb begin
    o_onehot = 4'b0000;
    o_idx    = 2'd0;
    o_valid  = 1'b0;
    w_cand   = i_ptr;
    for (int i = 0; i < 4; i++) begin
      // The 2-bit add wraps the search modulo 4.
      w_cand = i_ptr + 2'(i);
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aurora_tx_arbiter.sv
// ============================================================================
// Module      : aurora_tx_arbiter
// Description : Round-robin scheduler for four DFX frame sources onto one
//               64-bit Aurora link. It captures the granted frame and sends
//               it as 19 header-tagged beats.
// Ports       : clk, rst (sync, active-high); req/data_dfx_in from sources;
//               grant one-cycle one-hot pulse; axis (master) beat channel;
//               busy (not IDLE); cur_src (source being sent)
// Config      : ARB_IFG_EN - insert one GAP cycle after each tlast beat
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_tx_arbiter #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = aurora_pkt_pkg::NUMBER_PACKET,
  parameter int FRAG_WIDTH        = aurora_pkt_pkg::FRAG_WIDTH,
  parameter int NUM_SRC           = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                req,
  input  logic [NUM_SRC*DATA_DFX_WIDTH-1:0] data_dfx_in,
  output logic [NUM_SRC-1:0]                grant,
  aurora_tx_arbiter_if.master               axis,
  output logic                              busy,
  output logic [1:0]                        cur_src
);
  import aurora_pkt_pkg::*;

  // The frame is zero-extended to a whole number of fragments. The tail
  // fragment then slices like the others, and its upper bits read as zero.
  localparam int PAD_BITS   = FRAG_WIDTH - LAST_FRAG_BITS;
  localparam int PAD_WIDTH  = NUMBER_PACKET * FRAG_WIDTH;

  logic [1:0]                   r_state;
  logic [1:0]                   r_ptr;
  logic [NUM_SRC-1:0]           r_grant;
  logic [1:0]                   r_cur_src;
  logic [4:0]                   r_frag;
  logic [DATA_DFX_WIDTH-1:0]    r_frame;

  logic [3:0]                   w_win_onehot;
  logic [1:0]                   w_win_idx;
  logic                         w_win_valid;
  logic [DATA_DFX_WIDTH-1:0]    w_win_frame;
  logic [PAD_WIDTH-1:0]         w_frame_pad;
  logic [FRAG_WIDTH-1:0]        w_payload;
  logic                         w_send;
  logic [AURORA_DATA_WIDTH-1:0] w_beat;

  rr_arbiter_4 u_rr (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  assign w_win_frame = data_dfx_in[int'(w_win_idx)*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_grant   <= '0;
      r_cur_src <= 2'd0;
      r_frag    <= 5'd0;
      r_frame   <= '0;
    end else begin
      r_grant <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_frame   <= w_win_frame;
            r_cur_src <= w_win_idx;
            r_grant   <= w_win_onehot;
            r_ptr     <= w_win_idx + 2'd1;
            r_frag    <= 5'd0;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tvalid is always high in SEND, so tready alone marks acceptance.
          if (axis.m_axis_tready) begin
            if (r_frag == LAST_FRAG) begin
`ifdef ARB_IFG_EN
              r_state <= ST_GAP;
`else
              r_state <= ST_IDLE;
`endif
            end else begin
              r_frag <= r_frag + 5'd1;
            end
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_send      = (r_state == ST_SEND);
  assign w_frame_pad = {{PAD_BITS{1'b0}}, r_frame};
  assign w_payload   = w_frame_pad[int'(r_frag)*FRAG_WIDTH +: FRAG_WIDTH];

  always_comb begin
    w_beat = '0;
    if (w_send) begin
      w_beat[SRC_MSB:SRC_LSB]              = r_cur_src;
      w_beat[PKT_MSB:PKT_LSB]              = r_frag;
      w_beat[PAYLOAD_LSB +: FRAG_WIDTH]    = w_payload;
    end
  end

  assign axis.m_axis_tdata  = w_beat;
  assign axis.m_axis_tvalid = w_send;
  assign axis.m_axis_tlast  = w_send && (r_frag == LAST_FRAG);
  assign grant              = r_grant;
  assign busy               = (r_state != ST_IDLE);
  assign cur_src            = r_cur_src;

endmodule

`default_nettype wire

// File: tb/tb_aurora_tx_arbiter.sv
// ============================================================================
// Module      : tb_aurora_tx_arbiter
// Description : Scoreboard bench for aurora_tx_arbiter. Expected grants and
//               beats are queued when requests are driven and are compared
//               as the link accepts beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aurora_tx_arbiter;

  localparam int DDW = 1034;
  localparam int NS  = 4;
`ifdef ARB_IFG_EN
  localparam int GAP_EXP = 2;
`else
  localparam int GAP_EXP = 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NS-1:0]       req = '0;
  logic [NS*DDW-1:0]   data_dfx_in = '0;
  logic [NS-1:0]       grant;
  logic                busy;
  logic [1:0]          cur_src;

  aurora_tx_arbiter_if #(.AURORA_DATA_WIDTH(64)) axis_if ();

  aurora_tx_arbiter #(
    .DATA_WIDTH(1024), .ADDR_WIDTH(10), .DATA_DFX_WIDTH(DDW),
    .AURORA_DATA_WIDTH(64), .NUMBER_PACKET(19), .FRAG_WIDTH(55), .NUM_SRC(NS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_dfx_in (data_dfx_in),
    .grant       (grant),
    .axis        (axis_if),
    .busy        (busy),
    .cur_src     (cur_src)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [64:0] exp_beat[$];
  logic [5:0]  exp_grant[$];     // {src, onehot}
  int          n_acc    = 0;
  int          gap_cnt  = 0;
  bit          gap_armed = 1'b0;
  int          gap_min  = 1000;
  int          gap_max  = -1;
  logic [63:0] last_tlast_data = '0;
  int          m_ptr    = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  task automatic expect_frame(input int src, input logic [DDW-1:0] fr);
    logic [64:0] b;
    int          idx;
    exp_grant.push_back({2'(src), 4'(1 << src)});
    for (int f = 0; f < 19; f++) begin
      b      = '0;
      b[1:0] = 2'(src);
      b[6:2] = 5'(f);
      for (int j = 0; j < 55; j++) begin
        idx = f * 55 + j;
        if (idx < DDW) b[9 + j] = fr[idx];
      end
      b[64] = (f == 18);
      exp_beat.push_back(b);
    end
    m_ptr = (src + 1) % 4;
  endtask

  task automatic rand_frame(output logic [DDW-1:0] fr);
    for (int i = 0; i < DDW; i++) fr[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (grant != 4'b0) begin
        g = grant;
        return;
      end
    end
    check_eq("grant_timeout", g, 4'hF);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 300; i++) begin
      if (n_acc >= target) return;
      tick();
    end
    check_eq("acc_timeout", n_acc, target);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_beat.size() == 0 && exp_grant.size() == 0 && !busy) return;
      tick();
    end
    check_eq("drain_timeout", exp_beat.size(), 0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [5:0]  eg;
    logic [64:0] act;
    if (!rst) begin
      if (grant !== 4'b0) begin
        if (exp_grant.size() == 0) check_eq("grant_unexpected", grant, 4'b0);
        else begin
          eg = exp_grant.pop_front();
          check_eq("grant", grant, eg[3:0]);
          check_eq("cur_src", cur_src, eg[5:4]);
        end
      end
      act = {axis_if.m_axis_tlast, axis_if.m_axis_tdata};
      if (axis_if.m_axis_tvalid) begin
        if (gap_armed) begin
          if (gap_cnt < 10) begin
            if (gap_cnt < gap_min) gap_min = gap_cnt;
            if (gap_cnt > gap_max) gap_max = gap_cnt;
          end
          gap_armed = 1'b0;
        end
        if (exp_beat.size() == 0) check_eq("beat_unexpected", exp_beat.size(), 1);
        else if (axis_if.m_axis_tready) begin
          check_eq("beat", act, exp_beat.pop_front());
          n_acc++;
          if (axis_if.m_axis_tlast) begin
            gap_armed       = 1'b1;
            gap_cnt         = 0;
            last_tlast_data = axis_if.m_axis_tdata;
          end
        end else begin
          check_eq("bp_hold", act, exp_beat[0]);
        end
      end else if (gap_armed) begin
        gap_cnt++;
      end
    end
  end

  initial begin
    logic [DDW-1:0] fr [4];
    logic [DDW-1:0] fr0b;
    logic [DDW-1:0] f;
    logic [7:0]     bv;
    logic [3:0]     g;
    logic [3:0]     act_mask;
    bit             first0;
    int             k;
    int             base;

    axis_if.m_axis_tready = 1'b1;

    // ---------------- Fairness, all requests held from reset -------------
    for (int s = 0; s < 4; s++) begin
      rand_frame(fr[s]);
      data_dfx_in[s*DDW +: DDW] = fr[s];
    end
    rand_frame(fr0b);
    req = 4'hF;
    rst = 1'b1;
    tick(); tick(); tick();
    check_eq("rst_grant",  grant, 4'b0);
    check_eq("rst_tvalid", axis_if.m_axis_tvalid, 1'b0);
    check_eq("rst_tlast",  axis_if.m_axis_tlast, 1'b0);
    check_eq("rst_tdata",  axis_if.m_axis_tdata, 64'h0);
    check_eq("rst_busy",   busy, 1'b0);
    check_eq("rst_cur_src", cur_src, 2'd0);

    m_ptr    = 0;
    act_mask = 4'hF;
    first0   = 1'b1;
    for (int n = 0; n < 5; n++) begin
      k = rr_pick(act_mask, m_ptr);
      expect_frame(k, (k == 0 && !first0) ? fr0b : fr[k]);
      if (k == 0 && first0) first0 = 1'b0;
      else act_mask[k] = 1'b0;
    end
    rst = 1'b0;
    first0 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      if (g == 4'b0001 && first0) begin
        data_dfx_in[0 +: DDW] = fr0b;
        first0 = 1'b0;
      end else begin
        req = req & ~g;
      end
    end
    req = '0;
    wait_drain();
    check_eq("gap_min", gap_min, GAP_EXP);
    check_eq("gap_max", gap_max, GAP_EXP);

    // ---------------- Single frame from source 2, incrementing bytes -----
    for (int i = 0; i < DDW; i++) begin
      bv   = 8'(i / 8);
      f[i] = bv[i % 8];
    end
    data_dfx_in[2*DDW +: DDW] = f;
    expect_frame(2, f);
    req = 4'b0100;
    tick();
    check_eq("lat_grant",  grant, 4'b0100);
    check_eq("lat_tvalid", axis_if.m_axis_tvalid, 1'b1);
    req = '0;
    wait_drain();

    // ---------------- Last fragment boundary, source 0 -------------------
    f = '0;
    f[1033:990] = '1;
    data_dfx_in[0 +: DDW] = f;
    expect_frame(0, f);
    req = 4'b0001;
    wait_grant(g);
    req = '0;
    wait_drain();
    check_eq("last_frag_data", last_tlast_data, 64'h001F_FFFF_FFFF_FE48);

    // ---------------- Backpressure at beat 5, source 3 -------------------
    rand_frame(f);
    data_dfx_in[3*DDW +: DDW] = f;
    expect_frame(3, f);
    base = n_acc;
    req  = 4'b1000;
    wait_grant(g);
    req = '0;
    wait_acc(base + 5);
    axis_if.m_axis_tready = 1'b0;
    tick(); tick(); tick();
    axis_if.m_axis_tready = 1'b1;
    wait_drain();
    check_eq("bp_count", n_acc - base, 19);

    // ---------------- Reset mid-frame, source 2 ---------------------------
    rand_frame(f);
    data_dfx_in[2*DDW +: DDW] = f;
    expect_frame(2, f);
    base = n_acc;
    req  = 4'b0100;
    wait_grant(g);
    req = '0;
    wait_acc(base + 10);
    rst = 1'b1;
    exp_beat.delete();
    exp_grant.delete();
    m_ptr = 0;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_tvalid", axis_if.m_axis_tvalid, 1'b0);
    check_eq("mid_rst_busy",   busy, 1'b0);

    // Sources 1 and 3 compete; a reset pointer must favour source 1 first.
    rand_frame(fr[1]);
    rand_frame(fr[3]);
    data_dfx_in[1*DDW +: DDW] = fr[1];
    data_dfx_in[3*DDW +: DDW] = fr[3];
    act_mask = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      k = rr_pick(act_mask, m_ptr);
      expect_frame(k, fr[k]);
      act_mask[k] = 1'b0;
    end
    req = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      wait_grant(g);
      req = req & ~g;
    end
    req = '0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
